// File: rtl/i2s_pkg.sv
// Shared constants, FSM state type and helpers for the I2S DAC transmitter.
package i2s_pkg;

  // Default channel width; a frame carries one left and one right word.
  localparam int SLOTS_PER_CH = 32;
  localparam int FRAME_SLOTS  = 2 * SLOTS_PER_CH;

  // Word-select level during the left half-frame.
  localparam logic LEFT_LRCK = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_e;

  // Bit slots per frame for an arbitrary channel width.
  function automatic int frame_slots(input int data_width);
    return data_width * (FRAME_SLOTS / SLOTS_PER_CH);
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit/word clock generator: BCLK divider, slot counter, LRCK and frame strobes.
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = SLOTS_PER_CH,
  parameter int BCLK_DIV   = 4
) (
  input  logic audio_clk,
  input  logic reset_n,
  output logic aud_bclk,
  output logic aud_daclrck,
  output logic fall_stb,
  output logic fs_stb
);

  localparam int FRAME_LEN = frame_slots(DATA_WIDTH);
  localparam int DIV_W     = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SLOT_W    = $clog2(FRAME_LEN);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_LEN - 1);
  localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(DATA_WIDTH);

  logic [DIV_W-1:0]  div_q;
  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_nxt;
  logic              div_tc;

  // Strobes are combinational so the serializer updates on the same edge BCLK falls.
  assign div_tc   = (div_q == DIV_LAST);
  assign fall_stb = div_tc & aud_bclk;
  assign fs_stb   = fall_stb & (slot_q == SLOT_LAST);
  assign slot_nxt = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);

  // Divider, BCLK toggle, slot counter and word select; slot resets to the last
  // slot so the first BCLK fall after reset is a frame start.
  always_ff @(posedge audio_clk) begin
    if (!reset_n) begin
      div_q       <= '0;
      aud_bclk    <= 1'b1;
      slot_q      <= SLOT_LAST;
      aud_daclrck <= LEFT_LRCK;
    end else begin
      div_q <= div_tc ? '0 : div_q + DIV_W'(1);
      if (div_tc) begin
        aud_bclk <= ~aud_bclk;
      end
      if (fall_stb) begin
        slot_q      <= slot_nxt;
        aud_daclrck <= (slot_nxt >= SLOT_RIGHT) ? ~LEFT_LRCK : LEFT_LRCK;
      end
    end
  end

endmodule

// File: rtl/i2s_dac_tx.sv
// Stereo I2S transmitter: one-deep L/R holding buffers, frame FSM, Philips-format
// serializer and saturating underrun counter.
module i2s_dac_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = SLOTS_PER_CH,
  parameter int BCLK_DIV   = 4,
  parameter int UCNT_WIDTH = 16
) (
  input  logic                  audio_clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] dacL_data_in,
  input  logic                  dacL_valid_in,
  output logic                  dacL_ready_out,
  input  logic [DATA_WIDTH-1:0] dacR_data_in,
  input  logic                  dacR_valid_in,
  output logic                  dacR_ready_out,
  output logic                  aud_bclk,
  output logic                  aud_daclrck,
  output logic                  aud_dacdat,
  output logic                  underrun,
  output logic [UCNT_WIDTH-1:0] underrun_count
);

  localparam int FRAME_LEN = frame_slots(DATA_WIDTH);

  logic                         fall_stb;
  logic                         fs_stb;
  i2s_state_e                   state_q;
  i2s_state_e                   state_d;
  logic                         load_frame;
  logic                         underrun_d;
  logic signed [DATA_WIDTH-1:0] buf_l;
  logic signed [DATA_WIDTH-1:0] buf_r;
  logic                         full_l;
  logic                         full_r;
  logic                         full_l_d;
  logic                         full_r_d;
  logic                         xfer_l;
  logic                         xfer_r;
  logic [FRAME_LEN-1:0]         frame_word;
  logic [FRAME_LEN-1:0]         shift_q;
  logic                         dly_q;

  function automatic logic [UCNT_WIDTH-1:0] sat_inc(input logic [UCNT_WIDTH-1:0] v);
    return (&v) ? v : v + UCNT_WIDTH'(1);
  endfunction

  i2s_clk_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .BCLK_DIV   (BCLK_DIV)
  ) u_clk_gen (
    .audio_clk   (audio_clk),
    .reset_n     (reset_n),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .fall_stb    (fall_stb),
    .fs_stb      (fs_stb)
  );

  // Handshake: a buffer cleared at frame start can only be refilled afterwards,
  // because its ready was low while it was full.
  assign xfer_l     = dacL_valid_in & dacL_ready_out;
  assign xfer_r     = dacR_valid_in & dacR_ready_out;
  assign full_l_d   = load_frame ? 1'b0 : (full_l | xfer_l);
  assign full_r_d   = load_frame ? 1'b0 : (full_r | xfer_r);
  assign frame_word = load_frame ? {buf_l, buf_r} : '0;

  // Frame FSM: decisions are taken only at frame start.
  always_comb begin
    state_d    = state_q;
    load_frame = 1'b0;
    underrun_d = 1'b0;
    if (fs_stb) begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = RUN;
        end
        RUN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (full_l && full_r) begin
            load_frame = 1'b1;
          end else begin
            underrun_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state: FSM, buffer flags, ready (from next-state flags), underrun.
  always_ff @(posedge audio_clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      full_l         <= 1'b0;
      full_r         <= 1'b0;
      dacL_ready_out <= 1'b0;
      dacR_ready_out <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      state_q        <= state_d;
      full_l         <= full_l_d;
      full_r         <= full_r_d;
      dacL_ready_out <= enable & ~full_l_d;
      dacR_ready_out <= enable & ~full_r_d;
      underrun       <= underrun_d;
      if (underrun_d) begin
        underrun_count <= sat_inc(underrun_count);
      end
    end
  end

  // Sample holding buffers; validity lives in the full flags.
  always_ff @(posedge audio_clk) begin
    if (xfer_l) buf_l <= dacL_data_in;
    if (xfer_r) buf_r <= dacR_data_in;
  end

  // Serializer: MSB-first shift register feeding a one-slot delay flop, which
  // gives the I2S one-bit lag (slot 0 carries the previous word's LSB).
  always_ff @(posedge audio_clk) begin
    if (!reset_n) begin
      shift_q    <= '0;
      dly_q      <= 1'b0;
      aud_dacdat <= 1'b0;
    end else if (fall_stb) begin
      aud_dacdat <= dly_q;
      if (fs_stb) begin
        dly_q   <= frame_word[FRAME_LEN-1];
        shift_q <= {frame_word[FRAME_LEN-2:0], 1'b0};
      end else begin
        dly_q   <= shift_q[FRAME_LEN-1];
        shift_q <= {shift_q[FRAME_LEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx (DATA_WIDTH=32, BCLK_DIV=2, UCNT_WIDTH=2).
module tb_i2s_dac_tx;

  localparam int DW  = 32;
  localparam int DIV = 2;
  localparam int UW  = 2;
  localparam int FL  = 2 * DW;
  localparam int UMAX = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] d_l, d_r;
  logic          v_l, v_r;
  logic          rdy_l, rdy_r;
  logic          bclk, lrck, dat, under;
  logic [UW-1:0] ucnt;

  always #5 clk = ~clk;

  i2s_dac_tx #(.DATA_WIDTH(DW), .BCLK_DIV(DIV), .UCNT_WIDTH(UW)) dut (
    .audio_clk      (clk),
    .reset_n        (rst_n),
    .enable         (en),
    .dacL_data_in   (d_l),
    .dacL_valid_in  (v_l),
    .dacL_ready_out (rdy_l),
    .dacR_data_in   (d_r),
    .dacR_valid_in  (v_r),
    .dacR_ready_out (rdy_r),
    .aud_bclk       (bclk),
    .aud_daclrck    (lrck),
    .aud_dacdat     (dat),
    .underrun       (under),
    .underrun_count (ucnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (time-indexed) ----------------
  int          t;
  bit          m_live = 0;
  bit          m_run, m_full_l, m_full_r, m_under, m_rdy_l, m_rdy_r;
  logic [DW-1:0] m_buf_l, m_buf_r;
  logic [FL-1:0] m_cur, m_prev;
  int          m_ucnt;
  int          fs_cnt = 0;
  int          m_slot = -1;
  bit          m_bclk, m_lrck, m_dat;

  initial begin : model
    int h, f;
    bit fall, fs, xl, xr;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        t = 0; m_run = 0; m_full_l = 0; m_full_r = 0; m_under = 0;
        m_rdy_l = 0; m_rdy_r = 0; m_ucnt = 0; m_cur = '0; m_prev = '0;
        m_live = 1;
      end else begin
        xl = v_l && m_rdy_l;
        xr = v_r && m_rdy_r;
        t++;
        h = t / DIV;
        fall = (t % DIV == 0) && (h % 2 == 1);
        f = (h + 1) / 2;
        fs = fall && ((f - 1) % FL == 0);
        m_under = 0;
        if (fs) begin
          m_prev = m_cur;
          m_cur = '0;
          if (m_run && en) begin
            if (m_full_l && m_full_r) begin
              m_cur = {m_buf_l, m_buf_r};
              m_full_l = 0; m_full_r = 0;
            end else begin
              m_under = 1;
              if (m_ucnt < UMAX) m_ucnt++;
            end
          end
          m_run = en;
          fs_cnt++;
        end
        if (xl) begin m_buf_l = d_l; m_full_l = 1; end
        if (xr) begin m_buf_r = d_r; m_full_r = 1; end
        m_rdy_l = en && !m_full_l;
        m_rdy_r = en && !m_full_r;
      end
      h = t / DIV;
      f = (h + 1) / 2;
      m_bclk = (h % 2 == 0);
      if (f == 0) begin
        m_slot = -1; m_lrck = 0; m_dat = 0;
      end else begin
        m_slot = (f - 1) % FL;
        m_lrck = (m_slot >= DW);
        m_dat  = (m_slot == 0) ? m_prev[0] : m_cur[FL - m_slot];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("bclk", bclk, m_bclk);
        chk("lrck", lrck, m_lrck);
        chk("dacdat", dat, m_dat);
        chk("ready_l", rdy_l, m_rdy_l);
        chk("ready_r", rdy_r, m_rdy_r);
        chk("underrun", under, m_under);
        chk("underrun_count", ucnt, m_ucnt);
      end
    end
  end

  // Frame capture from the DUT pins alone: at each left-half start, the last
  // 64 falling-edge bits are the complete {L,R} of the frame just finished.
  logic [FL-1:0] played[$];
  initial begin : capture
    logic [FL-1:0] cap;
    bit pb, pl;
    cap = '0; pb = 1; pl = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cap = '0; pb = 1; pl = 0;
      end else begin
        if (pb && !bclk) begin
          cap = {cap[FL-2:0], dat};
          if (pl && !lrck) played.push_back(cap);
          pl = lrck;
        end
        pb = bclk;
      end
    end
  end

  function automatic logic [FL-1:0] last_played();
    return (played.size() > 0) ? played[played.size()-1] : '1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic timeout(input string name);
    checks++; failures++;
    $display("FAIL %s timeout actual=expired required=event", name);
  endtask

  task automatic wait_fs();
    int n0, k;
    n0 = fs_cnt; k = 0;
    while (fs_cnt == n0 && k < 600) begin cyc(1); k++; end
    if (fs_cnt == n0) timeout("wait_fs");
  endtask

  task automatic wait_slot(input int s);
    int k;
    k = 0;
    while (m_slot != s && k < 600) begin cyc(1); k++; end
    if (m_slot != s) timeout("wait_slot");
  endtask

  task automatic push_l(input logic [DW-1:0] x);
    int k;
    k = 0;
    while (!rdy_l && k < 600) begin cyc(1); k++; end
    if (!rdy_l) timeout("push_l");
    d_l = x; v_l = 1; cyc(1); v_l = 0;
  endtask

  task automatic push_r(input logic [DW-1:0] x);
    int k;
    k = 0;
    while (!rdy_r && k < 600) begin cyc(1); k++; end
    if (!rdy_r) timeout("push_r");
    d_r = x; v_r = 1; cyc(1); v_r = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bclk"}, bclk, 1'b1);
    chk({tag, "_lrck"}, lrck, 1'b0);
    chk({tag, "_dacdat"}, dat, 1'b0);
    chk({tag, "_ready_l"}, rdy_l, 1'b0);
    chk({tag, "_ready_r"}, rdy_r, 1'b0);
    chk({tag, "_underrun"}, under, 1'b0);
    chk({tag, "_count"}, ucnt, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin : stim
    int sl, sr, guard, base, idx, last_fs, nx;
    bit tl, tr;
    rst_n = 0; en = 0; v_l = 0; v_r = 0; d_l = '0; d_r = '0;
    cyc(3);
    chk_reset_vals("reset");

    // Reset then idle: BCLK period 4 with first fall at cycle 2, LRCK period 256.
    rst_n = 1;
    cyc(1); chk("bclk_c1", bclk, 1'b1);
    cyc(1); chk("bclk_first_fall_c2", bclk, 1'b0);
    cyc(1); chk("bclk_c3", bclk, 1'b0);
    cyc(1); chk("bclk_c4", bclk, 1'b1);
    cyc(125); chk("lrck_c129", lrck, 1'b0);
    cyc(1);   chk("lrck_c130", lrck, 1'b1);
    cyc(127); chk("lrck_c257", lrck, 1'b1);
    cyc(1);   chk("lrck_c258", lrck, 1'b0);
    cyc(342);
    chk("idle_count", ucnt, 0);
    chk("idle_ready_l", rdy_l, 1'b0);

    // Single pair.
    en = 1;
    wait_fs();
    chk("idle_to_run_no_underrun", under, 1'b0);
    push_l(32'hA5A5_0001);
    push_r(32'h8000_0000);
    chk("full_ready_l", rdy_l, 1'b0);
    chk("full_ready_r", rdy_r, 1'b0);
    wait_fs();
    chk("clear_ready_l", rdy_l, 1'b1);
    chk("clear_ready_r", rdy_r, 1'b1);
    chk("load_no_underrun", under, 1'b0);
    chk("slot0_prev_lsb", dat, 1'b0);
    cyc(3); chk("pre_msb", dat, 1'b0);
    cyc(1); chk("left_msb_latency", dat, 1'b1);
    wait_slot(32); chk("left_lsb_in_right_slot0", dat, 1'b1);
    wait_slot(33); chk("right_msb", dat, 1'b1);
    wait_slot(34); chk("right_bit30", dat, 1'b0);

    // Starvation: counter 1, 2, 3 then saturated at 3.
    wait_fs();
    chk("pair_frame", last_played(), {32'hA5A5_0001, 32'h8000_0000});
    chk("starve1_pulse", under, 1'b1);
    chk("starve1_count", ucnt, 1);
    cyc(1); chk("starve1_pulse_end", under, 1'b0);
    wait_fs(); chk("starve2_count", ucnt, 2);
    wait_fs(); chk("starve3_count", ucnt, 3);
    wait_fs(); chk("starve_sat_count", ucnt, 3);
    chk("starve_sat_pulse", under, 1'b1);
    chk("starve_zero_frame", last_played(), 64'h0);

    // Half-present pair: L retained across an underrun frame.
    push_l(32'h1122_3344);
    wait_fs();
    chk("half_underrun", under, 1'b1);
    chk("half_l_retained", rdy_l, 1'b0);
    chk("half_r_ready", rdy_r, 1'b1);
    push_r(32'h5566_7788);
    wait_fs();
    chk("half_load", under, 1'b0);
    wait_fs();
    chk("half_frame", last_played(), {32'h1122_3344, 32'h5566_7788});

    // Backpressure: valid held high, sequence 1..8 on both channels.
    base = played.size();
    sl = 1; sr = 1; guard = 0; last_fs = fs_cnt; nx = 0;
    v_l = 1; d_l = 1; v_r = 1; d_r = 101;
    while ((sl <= 8 || sr <= 8) && guard < 4000) begin
      tl = v_l && rdy_l;
      tr = v_r && rdy_r;
      cyc(1); guard++;
      if (fs_cnt != last_fs) begin last_fs = fs_cnt; nx = 0; end
      if (tl) begin
        nx++;
        chk("one_left_xfer_per_frame", nx, 1);
        sl++;
        if (sl <= 8) d_l = sl; else v_l = 0;
      end
      if (tr) begin
        sr++;
        if (sr <= 8) d_r = 100 + sr; else v_r = 0;
      end
    end
    if (guard >= 4000) timeout("backpressure");
    v_l = 0; v_r = 0;
    wait_fs(); wait_fs();
    idx = base;
    while (idx < played.size() && played[idx] == 0) idx++;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("bp_seq_%0d", k),
          (idx + k - 1 < played.size()) ? played[idx + k - 1] : '1,
          {32'(k), 32'(100 + k)});
    end

    // Enable dropped at slot 40: frame completes, then zeros with no underrun.
    push_l(32'hDEAD_BEEF);
    push_r(32'h0F0F_0F0F);
    wait_fs();
    wait_slot(40);
    en = 0;
    cyc(1);
    chk("disable_ready_drop", rdy_l, 1'b0);
    wait_fs();
    chk("disable_frame_completes", last_played(), {32'hDEAD_BEEF, 32'h0F0F_0F0F});
    chk("disable_no_underrun", under, 1'b0);
    wait_fs();
    chk("disable_zero_frame", last_played(), 64'h0);
    chk("disable_no_underrun2", under, 1'b0);

    // Reset asserted at slot 20, then count restarts and saturates.
    en = 1;
    wait_fs();
    wait_slot(20);
    rst_n = 0;
    cyc(1);
    chk_reset_vals("midreset");
    rst_n = 1;
    wait_fs(); chk("post_reset_idle", ucnt, 0);
    wait_fs(); chk("post_reset_c1", ucnt, 1);
    wait_fs(); chk("post_reset_c2", ucnt, 2);
    wait_fs(); chk("post_reset_c3", ucnt, 3);
    wait_fs(); chk("post_reset_sat", ucnt, 3);
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
